// File: rtl/cartoon_compose_pkg.sv
// Shared definitions for the cartoon compose stage: HSV field layout,
// threshold FSM states and counter helpers.
package cartoon_compose_pkg;

  localparam int H_MSB = 23;
  localparam int S_MSB = 15;
  localparam int V_MSB = 7;

  localparam logic [19:0] CNT_MAX = 20'hF_FFFF;

  typedef enum logic [1:0] {
    ST_MANUAL,
    ST_ACCUM,
    ST_UPDATE
  } thr_state_t;

  // Edge counter increment that sticks at the top instead of wrapping.
  function automatic logic [19:0] sat_inc(input logic [19:0] c, input logic b);
    return (b && (c != CNT_MAX)) ? c + 20'd1 : c;
  endfunction

  // Saturation boost S + S/4, clipped to 8 bits via a 9-bit sum.
  function automatic logic [7:0] boost_sat(input logic [7:0] s);
    logic [8:0] t;
    t = {1'b0, s} + {3'b000, s[7:2]};
    return t[8] ? 8'hFF : t[7:0];
  endfunction

endpackage

// File: rtl/cartoon_thr_fsm.sv
// Adaptive edge threshold: counts edge pixels per frame and nudges the
// threshold up or down at each frame start.
module cartoon_thr_fsm
  import cartoon_compose_pkg::*;
#(
  parameter int THR_INIT = 64,
  parameter int THR_MIN  = 8,
  parameter int THR_STEP = 4,
  parameter int HI_CNT   = 40000,
  parameter int LO_CNT   = 10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        auto_thr,
  input  logic [7:0]  thr_manual,
  input  logic        frame_start,
  input  logic        e,
  output logic [7:0]  thr_cur,
  output logic [19:0] edge_cnt
);

  thr_state_t  state;
  logic [19:0] run_cnt;
  logic [19:0] frame_cnt;
  logic [8:0]  thr_up;
  logic [7:0]  thr_inc;
  logic [7:0]  thr_dec;

  assign thr_up  = {1'b0, thr_cur} + 9'(THR_STEP);
  assign thr_inc = thr_up[8] ? 8'hFF : thr_up[7:0];
  assign thr_dec = ({1'b0, thr_cur} < 9'(THR_MIN + THR_STEP)) ? 8'(THR_MIN)
                                                              : thr_cur - 8'(THR_STEP);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_MANUAL;
      run_cnt   <= '0;
      frame_cnt <= '0;
      thr_cur   <= 8'(THR_INIT);
      edge_cnt  <= '0;
    end else begin
      case (state)
        ST_MANUAL: begin
          if (auto_thr) begin
            // Keep thr_cur (last manual value) and count this pixel already.
            state   <= ST_ACCUM;
            run_cnt <= sat_inc(frame_start ? 20'd0 : run_cnt, e);
          end else begin
            thr_cur <= thr_manual;
            if (frame_start) run_cnt <= '0;
          end
        end
        ST_ACCUM: begin
          if (!auto_thr) begin
            state   <= ST_MANUAL;
            run_cnt <= '0;
          end else if (frame_start) begin
            // The frame-start pixel belongs to the new frame.
            state     <= ST_UPDATE;
            frame_cnt <= run_cnt;
            run_cnt   <= {19'd0, e};
          end else begin
            run_cnt <= sat_inc(run_cnt, e);
          end
        end
        ST_UPDATE: begin
          edge_cnt <= frame_cnt;
          if (frame_cnt > 20'(HI_CNT))      thr_cur <= thr_inc;
          else if (frame_cnt < 20'(LO_CNT)) thr_cur <= thr_dec;
          run_cnt <= sat_inc(run_cnt, e);
          state   <= auto_thr ? ST_ACCUM : ST_MANUAL;
        end
        default: state <= ST_MANUAL;
      endcase
    end
  end

endmodule

// File: rtl/cartoon_compose.sv
// Cartoon compose: edge threshold, 3-tap horizontal dilation, posterize and
// saturation boost of the blurred HSV pixel; fixed 3-cycle latency.
module cartoon_compose
  import cartoon_compose_pkg::*;
#(
  parameter int LINE_W    = 640,
  parameter int POST_BITS = 3,
  parameter int THR_INIT  = 64,
  parameter int THR_MIN   = 8,
  parameter int THR_STEP  = 4,
  parameter int HI_CNT    = 40000,
  parameter int LO_CNT    = 10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] col,
  input  logic [12:0] x_count,
  input  logic        en,
  input  logic        auto_thr,
  input  logic [7:0]  thr_manual,
  input  logic [7:0]  edge_in,
  input  logic [23:0] blur_in,
  input  logic [23:0] pass_in,
  output logic [23:0] pixel_out,
  output logic [23:0] pass_thru,
  output logic [7:0]  thr_cur,
  output logic [19:0] edge_cnt
);

  localparam logic [12:0] LAST_X = 13'(LINE_W - 1);
  localparam logic [7:0]  V_MASK = 8'(8'hFF << (8 - POST_BITS));

  logic [7:0]  thr_eff;
  logic        e_now;
  logic        frame_start;

  logic        s1_e;
  logic        s1_en;
  logic [12:0] s1_x;
  logic [23:0] s1_blur;
  logic [23:0] s1_pass;
  logic        e_prev;

  logic        s2_d;
  logic        s2_en;
  logic [23:0] s2_blur;
  logic [23:0] s2_pass;

  logic        d_now;
  logic [23:0] composed;

  assign thr_eff     = auto_thr ? thr_cur : thr_manual;
  assign e_now       = edge_in > thr_eff;
  assign frame_start = (col == 13'd0) && (x_count == 13'd0);

  // Neighbours of the stage-1 pixel: e_prev is x-1, the live input is x+1.
  assign d_now = s1_e
               | ((s1_x != 13'd0)  & e_prev)
               | ((s1_x != LAST_X) & e_now);

  // NOTE: always_comb assigns a default first so no path leaves composed unassigned (no latch).
  always_comb begin
    composed = s2_blur;
    if (s2_en) begin
      composed = {s2_blur[H_MSB:S_MSB+1],
                  boost_sat(s2_blur[S_MSB:V_MSB+1]),
                  s2_d ? 8'd0 : (s2_blur[V_MSB:0] & V_MASK)};
    end
  end

  // NOTE: datapath registers are reset as well, so outputs right after reset are defined zeros.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_e      <= 1'b0;
      s1_en     <= 1'b0;
      s1_x      <= '0;
      s1_blur   <= '0;
      s1_pass   <= '0;
      e_prev    <= 1'b0;
      s2_d      <= 1'b0;
      s2_en     <= 1'b0;
      s2_blur   <= '0;
      s2_pass   <= '0;
      pixel_out <= '0;
      pass_thru <= '0;
    end else begin
      s1_e      <= e_now;
      s1_en     <= en;
      s1_x      <= x_count;
      s1_blur   <= blur_in;
      s1_pass   <= pass_in;
      e_prev    <= s1_e;
      s2_d      <= d_now;
      s2_en     <= s1_en;
      s2_blur   <= s1_blur;
      s2_pass   <= s1_pass;
      pixel_out <= composed;
      pass_thru <= s2_pass;
    end
  end

  cartoon_thr_fsm #(
    .THR_INIT (THR_INIT),
    .THR_MIN  (THR_MIN),
    .THR_STEP (THR_STEP),
    .HI_CNT   (HI_CNT),
    .LO_CNT   (LO_CNT)
  ) u_thr_fsm (
    .clk         (clk),
    .rst         (rst),
    .auto_thr    (auto_thr),
    .thr_manual  (thr_manual),
    .frame_start (frame_start),
    .e           (e_now),
    .thr_cur     (thr_cur),
    .edge_cnt    (edge_cnt)
  );

endmodule

// File: tb/tb_cartoon_compose.sv
// Scoreboard bench for cartoon_compose, run with a short 16-pixel line and
// 128-pixel frames so adaptive-threshold frames stay cheap.
module tb_cartoon_compose;

  localparam int LINE_W    = 16;
  localparam int POST_BITS = 3;
  localparam int THR_INIT  = 64;
  localparam int THR_MIN   = 8;
  localparam int THR_STEP  = 4;
  localparam int HI_CNT    = 100;
  localparam int LO_CNT    = 20;
  localparam int FRAME_PIX = 8 * LINE_W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] col = '0;
  logic [12:0] x_count = '0;
  logic        en = 1'b0;
  logic        auto_thr = 1'b0;
  logic [7:0]  thr_manual = 8'd255;
  logic [7:0]  edge_in = '0;
  logic [23:0] blur_in = '0;
  logic [23:0] pass_in = '0;
  logic [23:0] pixel_out;
  logic [23:0] pass_thru;
  logic [7:0]  thr_cur;
  logic [19:0] edge_cnt;

  always #5 clk = ~clk;

  cartoon_compose #(
    .LINE_W    (LINE_W),
    .POST_BITS (POST_BITS),
    .THR_INIT  (THR_INIT),
    .THR_MIN   (THR_MIN),
    .THR_STEP  (THR_STEP),
    .HI_CNT    (HI_CNT),
    .LO_CNT    (LO_CNT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .col        (col),
    .x_count    (x_count),
    .en         (en),
    .auto_thr   (auto_thr),
    .thr_manual (thr_manual),
    .edge_in    (edge_in),
    .blur_in    (blur_in),
    .pass_in    (pass_in),
    .pixel_out  (pixel_out),
    .pass_thru  (pass_thru),
    .thr_cur    (thr_cur),
    .edge_cnt   (edge_cnt)
  );

  typedef struct {
    logic [12:0] col;
    logic [12:0] x;
    logic        en;
    logic [7:0]  thr;
    logic [7:0]  edge_v;
    logic [23:0] blur;
    logic [23:0] pass;
    logic        has_fix;
    logic [23:0] fix;
  } pix_t;

  typedef struct {
    logic [23:0] pix;
    logic [23:0] pass;
    int          due;
  } exp_t;

  pix_t        stim[$];
  bit          ev[$];
  string       stim_tag[$];
  exp_t        sb[$];
  string       sb_tag[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [23:0] pcnt = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply(input pix_t p);
    col        = p.col;
    x_count    = p.x;
    en         = p.en;
    thr_manual = p.thr;
    edge_in    = p.edge_v;
    blur_in    = p.blur;
    pass_in    = p.pass;
  endtask

  task automatic step();
    exp_t  x;
    string t;
    @(posedge clk);
    #1;
    cyc++;
    if (sb.size() > 0) begin
      if (sb[0].due == cyc) begin
        x = sb.pop_front();
        t = sb_tag.pop_front();
        check({t, ".pix"}, {8'd0, pixel_out}, {8'd0, x.pix});
        check({t, ".pass"}, {8'd0, pass_thru}, {8'd0, x.pass});
      end
    end
  endtask

  task automatic add_pix(input string tag, input int c, input int xx, input bit en_v,
                         input int thr_v, input int edge_v, input logic [23:0] blur_v,
                         input bit has_fix = 1'b0, input logic [23:0] fix_v = 24'd0);
    pix_t p;
    p.col     = 13'(c);
    p.x       = 13'(xx);
    p.en      = en_v;
    p.thr     = 8'(thr_v);
    p.edge_v  = 8'(edge_v);
    p.blur    = blur_v;
    p.pass    = pcnt;
    p.has_fix = has_fix;
    p.fix     = fix_v;
    pcnt      = pcnt + 24'd1;
    stim.push_back(p);
    ev.push_back(edge_v > thr_v);
    stim_tag.push_back(tag);
  endtask

  // Reference: integer arithmetic straight from the pixel definition.
  function automatic logic [23:0] model(input int i);
    pix_t p;
    int   s;
    int   v;
    bit   d;
    p = stim[i];
    if (!p.en) return p.blur;
    d = ev[i];
    if ((int'(p.x) != 0) && (i > 0)) d = d | ev[i-1];
    if ((int'(p.x) != LINE_W - 1) && (i + 1 < stim.size())) d = d | ev[i+1];
    s = int'(p.blur[15:8]);
    s = s + s / 4;
    if (s > 255) s = 255;
    v = int'(p.blur[7:0]);
    v = v - (v % (1 << (8 - POST_BITS)));
    if (d) v = 0;
    return {p.blur[23:16], 8'(s), 8'(v)};
  endfunction

  task automatic run_stream(input bit zero_lead);
    exp_t x;
    pix_t idle;
    for (int i = 0; i < stim.size(); i++) begin
      x.pix  = stim[i].has_fix ? stim[i].fix : model(i);
      x.pass = stim[i].pass;
      x.due  = cyc + 3;
      sb.push_back(x);
      sb_tag.push_back(stim_tag[i]);
      apply(stim[i]);
      step();
      if (zero_lead && (i < 2)) begin
        check("rst_lead.pix", {8'd0, pixel_out}, 32'd0);
        check("rst_lead.pass", {8'd0, pass_thru}, 32'd0);
      end
    end
    idle.col = 13'd1; idle.x = 13'd0; idle.en = 1'b0; idle.thr = 8'd255;
    idle.edge_v = 8'd0; idle.blur = '0; idle.pass = '0; idle.has_fix = 1'b0; idle.fix = '0;
    repeat (3) begin
      apply(idle);
      step();
    end
    stim.delete();
    ev.delete();
    stim_tag.delete();
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    check({tag, ".pix"}, {8'd0, pixel_out}, 32'd0);
    check({tag, ".pass"}, {8'd0, pass_thru}, 32'd0);
    check({tag, ".cnt"}, {12'd0, edge_cnt}, 32'd0);
    check({tag, ".thr"}, {24'd0, thr_cur}, 32'(THR_INIT));
    sb.delete();
    sb_tag.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drive_frame(input string tag, input int n_edges,
                             input int exp_cnt, input int exp_thr);
    for (int i = 0; i < FRAME_PIX; i++) begin
      col     = 13'(i / LINE_W);
      x_count = 13'(i % LINE_W);
      edge_in = (i < n_edges) ? 8'd255 : 8'd0;
      en      = 1'b1;
      blur_in = '0;
      pass_in = '0;
      step();
      if (i == 1) begin
        check({tag, ".cnt"}, {12'd0, edge_cnt}, 32'(exp_cnt));
        check({tag, ".thr"}, {24'd0, thr_cur}, 32'(exp_thr));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    #2;
    do_reset("reset0");

    // Manual-threshold pixel path: latency, boost, dilation, line ends, bypass.
    add_pix("lat",   1, 1, 1'b1, 255, $urandom_range(0, 255), 24'h4080B7, 1'b1, 24'h40A0A0);
    add_pix("satF0", 1, 2, 1'b1, 255, $urandom_range(0, 255), 24'h40F0FF, 1'b1, 24'h40FFE0);
    add_pix("sat40", 1, 3, 1'b1, 255, $urandom_range(0, 255), 24'h404011, 1'b1, 24'h405000);
    for (int xx = 4; xx <= 8; xx++)
      add_pix("ramp", 1, xx, 1'b1, 255, $urandom_range(0, 255), 24'($urandom));
    for (int xx = 0; xx < LINE_W; xx++) begin
      if (xx >= 3 && xx <= 7)
        add_pix("dil", 2, xx, 1'b1, 100, (xx == 5) ? 200 : $urandom_range(0, 100),
                24'h1140FF, 1'b1, (xx == 3 || xx == 7) ? 24'h1150E0 : 24'h115000);
      else
        add_pix("dil", 2, xx, 1'b1, 100, $urandom_range(0, 100),
                {8'($urandom), 8'($urandom), 8'hFF});
    end
    for (int xx = 0; xx < LINE_W; xx++)
      add_pix("lineend", 3, xx, 1'b1, 100, (xx == LINE_W - 1) ? 200 : $urandom_range(0, 100),
              24'h2240FF, xx >= LINE_W - 3, (xx == LINE_W - 3) ? 24'h2250E0 : 24'h225000);
    add_pix("nextline", 4, 0, 1'b1, 100, $urandom_range(0, 100), 24'h2240FF, 1'b1, 24'h2250E0);
    for (int xx = 1; xx <= 3; xx++)
      add_pix("nextline", 4, xx, 1'b1, 100, $urandom_range(0, 100), 24'($urandom));
    for (int xx = 4; xx <= 6; xx++)
      add_pix("en0", 4, xx, 1'b0, 100, 255, 24'h123456, 1'b1, 24'h123456);
    run_stream(1'b0);
    check("manual.thr", {24'd0, thr_cur}, {24'd0, thr_manual});

    // Adaptive threshold over whole frames.
    @(negedge clk);
    auto_thr = 1'b1;
    do_reset("reset1");
    drive_frame("fr_full", FRAME_PIX, 0, 64);
    drive_frame("fr_up", 0, FRAME_PIX, 68);
    drive_frame("fr_down", 50, 0, 64);
    drive_frame("fr_hold", 0, 50, 64);
    t = 64;
    for (int k = 0; k < 16; k++) begin
      t = (t - THR_STEP < THR_MIN) ? THR_MIN : t - THR_STEP;
      drive_frame("fr_clamp", 0, 0, t);
    end

    // auto_thr dropped mid-frame: partial count discarded, manual value takes over.
    for (int i = 0; i < 50; i++) begin
      col     = 13'(i / LINE_W);
      x_count = 13'(i % LINE_W);
      edge_in = 8'd255;
      if (i == 40) begin
        auto_thr   = 1'b0;
        thr_manual = 8'd33;
      end
      step();
    end
    check("drop.thr", {24'd0, thr_cur}, 32'd33);
    check("drop.cnt", {12'd0, edge_cnt}, 32'd0);
    col = '0; x_count = '0;
    step();
    x_count = 13'd1;
    step();
    check("drop.fs_cnt", {12'd0, edge_cnt}, 32'd0);

    // Reset in the middle of a line, then confirm the flushed pipeline.
    for (int i = 0; i <= 10; i++) begin
      col        = 13'd5;
      x_count    = 13'(i);
      en         = 1'b1;
      thr_manual = 8'd100;
      edge_in    = 8'($urandom);
      blur_in    = 24'($urandom);
      pass_in    = 24'(i + 1);
      step();
    end
    #2;
    do_reset("reset_mid");
    for (int xx = 0; xx < 6; xx++)
      add_pix("post_rst", 6, xx, 1'b1, 100, $urandom_range(0, 255), 24'($urandom | 32'h1));
    run_stream(1'b1);
    if (sb.size() != 0) check("sb_drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
